// File: rtl/led_pkg.sv
// led_pkg: shared FSM states, color width and latch-time default for the LED strip controller
package led_pkg;
    localparam int COLOR_W = 24;
    localparam int RESET_CYCLES_DEF = 8000;
    typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, WAIT, LATCH} state_t;
endpackage

// File: rtl/led_strip_ctrl_if.sv
// led_strip_ctrl_if: host write/frame port plus line_driver handshake of the strip controller
interface led_strip_ctrl_if;
    logic wr_en;
    logic [7:0] wr_addr;
    logic [led_pkg::COLOR_W-1:0] wr_data;
    logic frame_start;
    logic busy;
    logic frame_done;
    logic drv_code;
    logic drv_start;
    logic drv_done;
    modport master (
        output wr_en, wr_addr, wr_data, frame_start, drv_done,
        input busy, frame_done, drv_code, drv_start
    );
    modport slave (
        input wr_en, wr_addr, wr_data, frame_start, drv_done,
        output busy, frame_done, drv_code, drv_start
    );
endinterface

// File: rtl/led_color_ram.sv
// led_color_ram: NUM_LEDS x 24-bit color store, one write port and one combinational read port
module led_color_ram import led_pkg::*; #(
    parameter int NUM_LEDS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic we,
    input  logic [7:0] waddr,
    input  logic [COLOR_W-1:0] wdata,
    input  logic [7:0] raddr,
    output logic [COLOR_W-1:0] rdata
);
    localparam int AW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
    localparam logic [8:0] DEPTH = 9'(NUM_LEDS);
    logic [COLOR_W-1:0] mem [NUM_LEDS];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LEDS; i++) mem[i] <= '0;
        end else if (we && {1'b0, waddr} < DEPTH) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end
    assign rdata = {1'b0, raddr} < DEPTH ? mem[raddr[AW-1:0]] : '0;
endmodule

// File: rtl/led_strip_ctrl.sv
// led_strip_ctrl: streams the color store MSB-first, one bit per line_driver handshake, then holds the latch gap
module led_strip_ctrl import led_pkg::*; #(
    parameter int NUM_LEDS = 4,
    parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
    input logic clk,
    input logic rst,
    led_strip_ctrl_if.slave bus
);
    localparam int LW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
    localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES - 1);
    localparam logic [7:0] LED_LAST = 8'(NUM_LEDS - 1);
    localparam logic [4:0] BIT_LAST = 5'(COLOR_W - 1);
    state_t state;
    logic [7:0] led;
    logic [4:0] bits;
    logic [LW-1:0] lcnt;
    logic [COLOR_W-1:0] shift;
    logic [COLOR_W-1:0] rd_data;
    logic busy_q, done_q, code_q, start_q;
    led_color_ram #(.NUM_LEDS(NUM_LEDS)) u_ram (
        .clk(clk),
        .rst(rst),
        .we(bus.wr_en),
        .waddr(bus.wr_addr),
        .wdata(bus.wr_data),
        .raddr(led),
        .rdata(rd_data)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            led <= '0;
            bits <= '0;
            lcnt <= '0;
            shift <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            code_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.frame_start) begin
                    state <= LOAD;
                    busy_q <= 1'b1;
                    led <= '0;
                end
                LOAD: begin
                    shift <= rd_data;
                    code_q <= rd_data[COLOR_W-1];
                    bits <= '0;
                    start_q <= 1'b1;
                    state <= SEND;
                end
                SEND: state <= GAP;
                GAP: state <= WAIT;
                WAIT: if (bus.drv_done) begin
                    shift <= shift << 1;
                    bits <= bits + 5'd1;
                    if (bits != BIT_LAST) begin
                        code_q <= shift[COLOR_W-2];
                        start_q <= 1'b1;
                        state <= SEND;
                    end else if (led != LED_LAST) begin
                        led <= led + 8'd1;
                        state <= LOAD;
                    end else begin
                        lcnt <= '0;
                        state <= LATCH;
                    end
                end
                LATCH: if (lcnt == LATCH_LAST) begin
                    state <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    lcnt <= lcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // a start pulse already on the line is withdrawn as soon as reset is asserted
    assign bus.drv_start = start_q && !rst;
    assign bus.drv_code = code_q;
    assign bus.busy = busy_q;
    assign bus.frame_done = done_q;
endmodule
